ws2812_receiver: RTL

Single-wire WS2812-style NRZ decoder: it samples the serial LED data line and recovers the 24-bit pixel words and frame boundaries that the board's light controller and PWM serializer transmit. It sits on the FPGA as a loopback or monitor path. It lets the checkers board verify its LED output in hardware, and lets the bench check the serializer end to end without inspecting the LED chain. Pixels are emitted one per strobe in wire order, and a frame-done pulse marks each latch (reset) gap.

---
 rtl/ws2812_receiver.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/ws2812_receiver.sv
// WS2812-style NRZ line decoder: recovers 24-bit pixel words (MSB first, wire order)
// and frame boundaries from a single serial data line sampled on clk.
module ws2812_receiver #(
    parameter int unsigned SYS_FREQ_MHZ     = 100,
    parameter int unsigned BIT_THRESHOLD_NS = 625,
    parameter int unsigned MIN_HIGH_NS      = 150,
    parameter int unsigned MAX_HIGH_NS      = 1100,
    parameter int unsigned RESET_NS         = 50000,
    parameter int unsigned PIXEL_COUNT      = 64,
    localparam int unsigned IW              = $clog2(PIXEL_COUNT + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          din,
    output logic [23:0]   pixel_data,
    output logic [IW-1:0] pixel_index,
    output logic          pixel_valid,
    output logic          frame_done,
    output logic [IW-1:0] frame_pixels,
    output logic          overflow,
    output logic          bit_error,
    output logic          busy
);

    localparam int unsigned THRESH_CYCLES = BIT_THRESHOLD_NS * SYS_FREQ_MHZ / 1000;
    localparam int unsigned MIN_CYCLES    = MIN_HIGH_NS * SYS_FREQ_MHZ / 1000;
    localparam int unsigned MAX_CYCLES    = MAX_HIGH_NS * SYS_FREQ_MHZ / 1000;
    localparam int unsigned RESET_CYCLES  = RESET_NS * SYS_FREQ_MHZ / 1000;
    localparam int unsigned CW            = $clog2(RESET_CYCLES + 2);

    // hi_lo_cnt reads 0 in the cycle after an edge. On a falling edge the completed high
    // lasted cnt+1 cycles; on a steady level the level has lasted cnt+2 cycles so far.
    localparam logic [CW-1:0] CNT_SAT = CW'(RESET_CYCLES);
    localparam logic [CW-1:0] THR_Q   = CW'(THRESH_CYCLES - 1);
    localparam logic [CW-1:0] MIN_Q   = CW'(MIN_CYCLES - 1);
    localparam logic [CW-1:0] MAX_Q   = CW'(MAX_CYCLES - 1);
    localparam logic [CW-1:0] RST_Q   = CW'(RESET_CYCLES - 2);
    localparam logic [IW-1:0] PIX_LIM = IW'(PIXEL_COUNT);

    typedef enum logic [1:0] {StSync, StIdle, StHigh, StLow} state_e;

    state_e        state_q, state_d;
    logic          din_m, din_s, din_p;
    logic [CW-1:0] hi_lo_cnt;
    logic [22:0]   shift_q, shift_d;
    logic [4:0]    bit_cnt_q, bit_cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          ovf_q, ovf_d;
    logic [23:0]   pdata_q, pdata_d;
    logic [IW-1:0] pindex_q, pindex_d;
    logic          pvalid_q, pvalid_d;
    logic          fdone_q, fdone_d;
    logic [IW-1:0] fpix_q, fpix_d;
    logic          berr_q, berr_d;

    logic din_edge, rise, fall;
    logic hi_too_long, hi_short, bit_val, low_done;

    assign din_edge = din_s ^ din_p;
    assign rise     = din_s & ~din_p;
    assign fall     = ~din_s & din_p;

    assign hi_too_long = din_s && (hi_lo_cnt >= MAX_Q);
    assign hi_short    = fall && (hi_lo_cnt < MIN_Q);
    assign bit_val     = hi_lo_cnt >= THR_Q;
    assign low_done    = !din_s && !din_edge && (hi_lo_cnt >= RST_Q);

    // Two-flop synchronizer plus a delayed copy for edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            din_m <= 1'b0;
            din_s <= 1'b0;
            din_p <= 1'b0;
        end else begin
            din_m <= din;
            din_s <= din_m;
            din_p <= din_s;
        end
    end

    // Level-duration counter: clears on any edge, saturates past the latch gap
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_lo_cnt <= '0;
        end else if (din_edge) begin
            hi_lo_cnt <= '0;
        end else if (hi_lo_cnt != CNT_SAT) begin
            hi_lo_cnt <= hi_lo_cnt + 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= StSync;
        else        state_q <= state_d;
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StSync: if (low_done) state_d = StIdle;
            StIdle: if (rise) state_d = StHigh;
            StHigh: begin
                if (hi_too_long || hi_short) state_d = StSync;
                else if (fall)               state_d = StLow;
            end
            StLow: begin
                if (rise)          state_d = StHigh;
                else if (low_done) state_d = StIdle;
            end
            default: state_d = StSync;
        endcase
    end

    // Datapath and registered-output next values
    always_comb begin
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        idx_d     = idx_q;
        ovf_d     = ovf_q;
        pdata_d   = pdata_q;
        pindex_d  = pindex_q;
        pvalid_d  = 1'b0;
        fdone_d   = 1'b0;
        fpix_d    = fpix_q;
        berr_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (rise) begin
                    idx_d     = '0;
                    bit_cnt_d = '0;
                    ovf_d     = 1'b0;
                end
            end
            StHigh: begin
                if (hi_too_long || hi_short) begin
                    berr_d = 1'b1;
                end else if (fall) begin
                    shift_d = {shift_q[21:0], bit_val};
                    if (bit_cnt_q == 5'd23) begin
                        bit_cnt_d = '0;
                        if (idx_q < PIX_LIM) begin
                            pdata_d  = {shift_q, bit_val};
                            pindex_d = idx_q;
                            pvalid_d = 1'b1;
                            idx_d    = idx_q + 1'b1;
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            StLow: begin
                if (!rise && low_done) begin
                    fdone_d = 1'b1;
                    fpix_d  = idx_q;
                    berr_d  = (bit_cnt_q != 5'd0);
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_q   <= '0;
            bit_cnt_q <= '0;
            idx_q     <= '0;
            ovf_q     <= 1'b0;
            pdata_q   <= '0;
            pindex_q  <= '0;
            pvalid_q  <= 1'b0;
            fdone_q   <= 1'b0;
            fpix_q    <= '0;
            berr_q    <= 1'b0;
        end else begin
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            idx_q     <= idx_d;
            ovf_q     <= ovf_d;
            pdata_q   <= pdata_d;
            pindex_q  <= pindex_d;
            pvalid_q  <= pvalid_d;
            fdone_q   <= fdone_d;
            fpix_q    <= fpix_d;
            berr_q    <= berr_d;
        end
    end

    assign pixel_data   = pdata_q;
    assign pixel_index  = pindex_q;
    assign pixel_valid  = pvalid_q;
    assign frame_done   = fdone_q;
    assign frame_pixels = fpix_q;
    assign overflow     = ovf_q;
    assign bit_error    = berr_q;
    assign busy         = (state_q == StHigh) || (state_q == StLow);

endmodule
